// File: rtl/fxp_pkg.sv
// ============================================================================
// Module      : fxp_pkg
// Description : Sign-magnitude fixed-point types and helper functions shared
//               by the round-robin adder scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fxp_pkg;

  // Default operand/result width: MSB is the sign, the rest is the magnitude.
  localparam int FXP_BITSIZE = 16;

  typedef logic [FXP_BITSIZE-1:0] fxp_t;

  // Sign bit of a sign-magnitude word.
  function automatic logic fxp_sign(input fxp_t v);
    return v[FXP_BITSIZE-1];
  endfunction

  // Magnitude field of a sign-magnitude word.
  function automatic logic [FXP_BITSIZE-2:0] fxp_mag(input fxp_t v);
    return v[FXP_BITSIZE-2:0];
  endfunction

  // Collapse negative zero onto positive zero.
  function automatic fxp_t fxp_neg_zero_fix(input fxp_t v);
    return (fxp_mag(v) == '0) ? '0 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fixed_point_add.sv
// ============================================================================
// Module      : fixed_point_add
// Description : Combinational sign-magnitude adder. Equal signs add the
//               magnitudes (wrapping); differing signs subtract the smaller
//               magnitude from the larger and take the larger's sign, with
//               ties taking B's sign. A zero result is always positive.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_point_add #(
  parameter int BITSIZE = 16
) (
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] b,
  output logic [BITSIZE-1:0] sum
);

  localparam int MW = BITSIZE - 1;

  logic          sa, sb, sr;
  logic [MW-1:0] ma, mb, mr;

  // Magnitude compare / add / subtract and sign selection.
  always_comb begin
    sa = a[BITSIZE-1];
    sb = b[BITSIZE-1];
    ma = a[MW-1:0];
    mb = b[MW-1:0];
    if (sa == sb) begin
      mr = ma + mb;
      sr = sa;
    end else if (ma > mb) begin
      mr = ma - mb;
      sr = sa;
    end else begin
      mr = mb - ma;
      sr = sb;
    end
    if (mr == '0) sr = 1'b0;
    sum = {sr, mr};
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Cyclic round-robin arbiter. Grants the first active request at
//               or after the pointer; the pointer moves past the winner on
//               every issued grant and holds otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] ptr;
  logic            found;

  // Cyclic search from the pointer; grant only when the pipeline can accept.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      int idx;
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        gnt_id = idx[ID_W-1:0];
      end
    end
    if (found && advance && rst_n) gnt[gnt_id] = 1'b1;
  end

  // Pointer moves to one past the granted index, wrapping at NUM_REQ.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fxp_add_rr_sched.sv
// ============================================================================
// Module      : fxp_add_rr_sched
// Description : Round-robin scheduler sharing one sign-magnitude adder among
//               NUM_REQ requesters. Stage 1 captures the granted operands,
//               stage 2 registers the sum with a valid/ready handshake.
//               Optional macro FXADD_RR_SAT_EN saturates same-sign magnitude
//               overflow and adds a sticky sat_flag output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fxp_add_rr_sched
  import fxp_pkg::*;
#(
  parameter int BITSIZE = FXP_BITSIZE,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*BITSIZE-1:0] a_flat,
  input  logic [NUM_REQ*BITSIZE-1:0] b_flat,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ID_W-1:0]            res_id,
  output logic [BITSIZE-1:0]         res_data,
  output logic                       busy
`ifdef FXADD_RR_SAT_EN
  ,
  output logic                       sat_flag
`endif
);

  logic               stall2, stall1, accept;
  logic [ID_W-1:0]    gnt_id;
  logic [BITSIZE-1:0] sel_a, sel_b;
  logic               s1_valid;
  logic [BITSIZE-1:0] s1_a, s1_b;
  logic [ID_W-1:0]    s1_id;
  logic [BITSIZE-1:0] add_sum, stage2_data;

  // Stage 1 only blocks when it is full and the output stage cannot drain.
  assign stall2 = res_valid & ~res_ready;
  assign stall1 = s1_valid & stall2;
  assign accept = ~stall1;
  assign busy   = s1_valid | res_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (accept),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  assign sel_a = a_flat[gnt_id*BITSIZE +: BITSIZE];
  assign sel_b = b_flat[gnt_id*BITSIZE +: BITSIZE];

  // Stage 1: capture the winner's operands and index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (accept) begin
      s1_valid <= |gnt;
      s1_a     <= sel_a;
      s1_b     <= sel_b;
      s1_id    <= gnt_id;
    end
  end

  fixed_point_add #(
    .BITSIZE (BITSIZE)
  ) u_add (
    .a   (s1_a),
    .b   (s1_b),
    .sum (add_sum)
  );

`ifdef FXADD_RR_SAT_EN
  logic [BITSIZE-1:0] mag_sum_ext;
  logic               sat_hit;

  // Same-sign magnitude carry clamps to the largest magnitude.
  assign mag_sum_ext = {1'b0, s1_a[BITSIZE-2:0]} + {1'b0, s1_b[BITSIZE-2:0]};
  assign sat_hit     = s1_valid & (s1_a[BITSIZE-1] == s1_b[BITSIZE-1]) & mag_sum_ext[BITSIZE-1];
  assign stage2_data = sat_hit ? {s1_a[BITSIZE-1], {(BITSIZE-1){1'b1}}} : add_sum;

  // Sticky saturation indicator, set when a saturated result is loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (!stall2 && sat_hit) begin
      sat_flag <= 1'b1;
    end
  end
`else
  assign stage2_data = add_sum;
`endif

  // Stage 2: register the sum; hold it while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (!stall2) begin
      res_valid <= s1_valid;
      res_data  <= stage2_data;
      res_id    <= s1_id;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fxp_add_rr_sched.sv
// ============================================================================
// Module      : tb_fxp_add_rr_sched
// Description : Self-checking bench for fxp_add_rr_sched with a scoreboard of
//               expected results (pushed on grant, popped on handshake).
//               Honours FXADD_RR_SAT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fxp_add_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] a_flat = '0;
  logic [63:0] b_flat = '0;
  logic        res_ready = 1'b1;
  logic [3:0]  gnt;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [15:0] res_data;
  logic        busy;
`ifdef FXADD_RR_SAT_EN
  logic        sat_flag;
`endif

  fxp_add_rr_sched #(
    .BITSIZE (16),
    .NUM_REQ (4),
    .ID_W    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
`ifdef FXADD_RR_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  gnt_log[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic [1:0]  prev_id = '0;
  logic [1:0]  mon_gi;
  exp_t        mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent sign-magnitude model using integer arithmetic.
  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
    int   ma, mb, mr;
    logic s;
    ma = int'(a[14:0]);
    mb = int'(b[14:0]);
    if (a[15] == b[15]) begin
      s  = a[15];
      mr = ma + mb;
      if (mr > 32767) begin
`ifdef FXADD_RR_SAT_EN
        mr = 32767;
`else
        mr = mr - 32768;
`endif
      end
    end else if (ma > mb) begin
      s  = a[15];
      mr = ma - mb;
    end else begin
      s  = b[15];
      mr = mb - ma;
    end
    if (mr == 0) s = 1'b0;
    return {s, mr[14:0]};
  endfunction

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    a_flat[i*16 +: 16] = a;
    b_flat[i*16 +: 16] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one-hot grants, scoreboard push/pop, output stability under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      chk("gnt_onehot0", {31'b0, $onehot0(gnt)}, 32'd1);
      if (prev_stall) begin
        chk("stall_hold_data", {16'b0, res_data}, {16'b0, prev_data});
        chk("stall_hold_id", {30'b0, res_id}, {30'b0, prev_id});
      end
      if (res_valid && res_ready) begin
        chk("sb_underflow", {31'b0, sb.size() == 0}, 32'd0);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("sb_res_id", {30'b0, res_id}, {30'b0, mon_e.id});
          chk("sb_res_data", {16'b0, res_data}, {16'b0, mon_e.data});
        end
      end
      if (gnt != 4'b0) begin
        mon_gi = 2'd0;
        for (int i = 0; i < 4; i++) if (gnt[i]) mon_gi = i[1:0];
        gnt_log.push_back(mon_gi);
        sb.push_back({mon_gi, model_add(a_flat[mon_gi*16 +: 16], b_flat[mon_gi*16 +: 16])});
      end
      prev_stall = res_valid && !res_ready;
      prev_data  = res_data;
      prev_id    = res_id;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, with requests asserted to show gnt is suppressed.
    rst_n = 1'b0;
    res_ready = 1'b1;
    req = 4'hF;
    tick();
    tick();
    @(negedge clk);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_res_id", {30'b0, res_id}, 32'd0);
    chk("rst_res_data", {16'b0, res_data}, 32'd0);
    chk("rst_gnt", {28'b0, gnt}, 32'd0);
`ifdef FXADD_RR_SAT_EN
    chk("rst_sat_flag", {31'b0, sat_flag}, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    req = 4'b0;
    tick();

    // Single requester: latency and basic sum.
    set_op(0, 16'h0005, 16'h0003);
    req = 4'b0001;
    @(negedge clk);
    chk("single_gnt", {28'b0, gnt}, 32'h1);
    chk("single_busy_t0", {31'b0, busy}, 32'd0);
    tick();
    req = 4'b0;
    @(negedge clk);
    chk("single_valid_t1", {31'b0, res_valid}, 32'd0);
    chk("single_busy_t1", {31'b0, busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("single_valid_t2", {31'b0, res_valid}, 32'd1);
    chk("single_res_id", {30'b0, res_id}, 32'd0);
    chk("single_res_data", {16'b0, res_data}, 32'h0008);
    tick();
    @(negedge clk);
    chk("single_valid_drop", {31'b0, res_valid}, 32'd0);
    chk("single_busy_idle", {31'b0, busy}, 32'd0);

    // Mixed signs on requester 2 (pointer is 1), held req = new transaction.
    set_op(2, 16'h8005, 16'h0003);
    req = 4'b0100;
    @(negedge clk);
    chk("mixed_gnt_a", {28'b0, gnt}, 32'h4);
    tick();
    set_op(2, 16'h8004, 16'h0004);
    @(negedge clk);
    chk("mixed_gnt_b", {28'b0, gnt}, 32'h4);
    tick();
    req = 4'b0;
    @(negedge clk);
    chk("mixed_res_a", {16'b0, res_data}, 32'h8002);
    tick();
    @(negedge clk);
    chk("mixed_res_b_valid", {31'b0, res_valid}, 32'd1);
    chk("mixed_res_b", {16'b0, res_data}, 32'h0000);
    chk("mixed_res_b_id", {30'b0, res_id}, 32'd2);
    tick();
    tick();

    // Overflow on requester 3 (pointer is 3); leaves the pointer at 0.
    set_op(3, 16'h7FFF, 16'h0001);
    req = 4'b1000;
    @(negedge clk);
    chk("ovf_gnt_a", {28'b0, gnt}, 32'h8);
    tick();
    set_op(3, 16'hFFFF, 16'h8001);
    @(negedge clk);
    chk("ovf_gnt_b", {28'b0, gnt}, 32'h8);
    tick();
    req = 4'b0;
    @(negedge clk);
`ifdef FXADD_RR_SAT_EN
    chk("ovf_res_a", {16'b0, res_data}, 32'h7FFF);
`else
    chk("ovf_res_a", {16'b0, res_data}, 32'h0000);
`endif
    tick();
    @(negedge clk);
`ifdef FXADD_RR_SAT_EN
    chk("ovf_res_b", {16'b0, res_data}, 32'hFFFF);
    chk("ovf_sat_flag", {31'b0, sat_flag}, 32'd1);
`else
    chk("ovf_res_b", {16'b0, res_data}, 32'h0000);
`endif
    tick();
    tick();

    // All four requesters held: grants cycle 0,1,2,3,0,1,2,3; one result per cycle.
    gnt_log.delete();
    for (int i = 0; i < 4; i++) set_op(i, 16'(i * 257 + 17), 16'(16'h8000 | (i * 3 + 2)));
    req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k >= 2) chk("rr_stream_valid", {31'b0, res_valid}, 32'd1);
      tick();
    end
    req = 4'b0;
    repeat (3) tick();
    chk("rr_log_len", 32'(gnt_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < gnt_log.size(); k++) begin
      chk("rr_order", {30'b0, gnt_log[k]}, 32'(k % 4));
    end
    chk("rr_sb_drained", 32'(sb.size()), 32'd0);

    // Backpressure with continuous requests.
    set_op(0, 16'h1234, 16'h0011);
    set_op(1, 16'h8100, 16'h0200);
    set_op(2, 16'h0001, 16'h8001);
    set_op(3, 16'h4000, 16'h3FFF);
    req = 4'hF;
    tick();
    tick();
    res_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_gnt", {28'b0, gnt}, 32'd0);
      chk("bp_valid", {31'b0, res_valid}, 32'd1);
      chk("bp_busy", {31'b0, busy}, 32'd1);
      tick();
    end
    res_ready = 1'b1;
    repeat (4) tick();
    req = 4'b0;
    repeat (3) tick();
    chk("bp_sb_drained", 32'(sb.size()), 32'd0);

    // Reset with both stages full.
    req = 4'hF;
    tick();
    tick();
    res_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_busy_full", {31'b0, busy}, 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 4'b0110;
    res_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {31'b0, res_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_gnt", {28'b0, gnt}, 32'h2);
`ifdef FXADD_RR_SAT_EN
    chk("mid_rst_sat", {31'b0, sat_flag}, 32'd0);
`endif
    tick();
    req = 4'b0;
    @(negedge clk);
    chk("mid_rst_no_early_valid", {31'b0, res_valid}, 32'd0);
    repeat (3) tick();
    chk("mid_sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
